// File: rtl/wb_stub_responder.sv
// Wishbone classic responder standing in for the USB device core during bring-up:
// word RAM, ID register, transaction counter and programmable wait states before ACK.
module wb_stub_responder #(
    parameter int          DEPTH_LOG2  = 4,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hC0DE0401
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_CYC,
    input  logic        wb_STB,
    input  logic        wb_WE,
    input  logic [13:0] wb_ADR,
    input  logic [3:0]  wb_SEL,
    input  logic [31:0] wb_DAT_MOSI,
    output logic [31:0] wb_DAT_MISO,
    output logic        wb_ACK,
    output logic        busy
);

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [13:0] ADR_ID  = 14'h1000;
    localparam logic [13:0] ADR_CNT = 14'h1001;
    localparam logic [13:0] ADR_CFG = 14'h1002;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state_q;
    logic [13:0] adr_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;
    logic [3:0]  wait_ctr_q;
    logic [3:0]  wait_cfg_q;
    logic [3:0]  wait_cfg_d;
    logic [15:0] txn_count_q;
    logic [15:0] txn_count_d;
    logic        ack_q;
    logic        busy_q;
    logic [31:0] miso_q;
    logic [31:0] mem [DEPTH];

    logic                  req;
    logic                  enter_ack;
    logic [13:0]           t_adr;
    logic                  t_we;
    logic [3:0]            t_sel;
    logic [31:0]           t_dat;
    logic                  t_ram;
    logic [DEPTH_LOG2-1:0] t_idx;
    logic [31:0]           rdata;

    assign req = wb_CYC & wb_STB;

    // With zero wait states the commit happens on the sampling edge itself,
    // so the transaction fields come straight from the bus in IDLE.
    always_comb begin
        enter_ack = 1'b0;
        t_adr     = adr_q;
        t_we      = we_q;
        t_sel     = sel_q;
        t_dat     = dat_q;
        case (state_q)
            S_IDLE: begin
                t_adr     = wb_ADR;
                t_we      = wb_WE;
                t_sel     = wb_SEL;
                t_dat     = wb_DAT_MOSI;
                enter_ack = req && (wait_cfg_q == 4'd0);
            end
            S_WAIT:  enter_ack = req && (wait_ctr_q <= 4'd1);
            default: enter_ack = 1'b0;
        endcase
    end

    always_comb begin
        t_ram = (t_adr[13:12] == 2'b00);
        t_idx = t_adr[DEPTH_LOG2-1:0];
        rdata = 32'h0;
        if (t_ram) begin
            rdata = mem[t_idx];
        end else begin
            case (t_adr)
                ADR_ID:  rdata = ID_VALUE;
                ADR_CNT: rdata = {16'h0, txn_count_q};
                ADR_CFG: rdata = {28'h0, wait_cfg_q};
                default: rdata = 32'h0;
            endcase
        end
    end

    // A clearing write to the counter wins over the increment of its own ACK.
    always_comb begin
        txn_count_d = txn_count_q + 16'd1;
        if (t_we && (t_adr == ADR_CNT) && (|t_sel)) begin
            txn_count_d = 16'h0;
        end
        wait_cfg_d = wait_cfg_q;
        if (t_we && (t_adr == ADR_CFG) && t_sel[0]) begin
            wait_cfg_d = t_dat[3:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            adr_q       <= 14'h0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            dat_q       <= 32'h0;
            wait_ctr_q  <= 4'h0;
            wait_cfg_q  <= 4'(WAIT_STATES);
            txn_count_q <= 16'h0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            miso_q      <= 32'h0;
        end else begin
            ack_q  <= 1'b0;
            miso_q <= 32'h0;
            if (enter_ack) begin
                ack_q       <= 1'b1;
                miso_q      <= t_we ? 32'h0 : rdata;
                txn_count_q <= txn_count_d;
                wait_cfg_q  <= wait_cfg_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        adr_q      <= wb_ADR;
                        we_q       <= wb_WE;
                        sel_q      <= wb_SEL;
                        dat_q      <= wb_DAT_MOSI;
                        wait_ctr_q <= wait_cfg_q;
                        busy_q     <= 1'b1;
                        state_q    <= (wait_cfg_q == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (wait_ctr_q <= 4'd1) begin
                        state_q <= S_ACK;
                    end else begin
                        wait_ctr_q <= wait_ctr_q - 4'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // RAM holds its contents across reset; the reset edge itself never commits.
    always_ff @(posedge clk) begin
        if (!rst && enter_ack && t_we && t_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (t_sel[i]) begin
                    mem[t_idx][8*i +: 8] <= t_dat[8*i +: 8];
                end
            end
        end
    end

    assign wb_ACK      = ack_q;
    assign wb_DAT_MISO = miso_q;
    assign busy        = busy_q;

endmodule

// File: doc/wb_stub_responder.md
Name: wb_stub_responder

Overview:
- Wishbone classic responder that answers the 14-bit-address, 32-bit-data transactions issued by the TT-pin-to-Wishbone initiator.
- Stands in for the USB device core on the control clock domain during bring-up and bench work.
- Provides a small word RAM, an ID register, a transaction counter and programmable wait states, so the initiator's timing paths get exercised with real handshakes.

Parameters:
- DEPTH_LOG2, 4, log2 of RAM depth in 32-bit words (16 words).
- WAIT_STATES, 1, reset value of the wait-state count (0..15) inserted before ACK.
- ID_VALUE, 32'hC0DE0401, constant returned by the ID register.

Ports:
- clk  input  1  control-domain clock.
- rst  input  1  asynchronous, active-high reset.
- wb_CYC  input  1  bus cycle valid.
- wb_STB  input  1  strobe; request valid when wb_CYC & wb_STB.
- wb_WE  input  1  1 = write, 0 = read.
- wb_ADR  input  14  word address.
- wb_SEL  input  4  byte lane enables; bit n covers DAT[8n+7:8n].
- wb_DAT_MOSI  input  32  write data from the initiator.
- wb_DAT_MISO  output  32  read data; valid only while wb_ACK=1, otherwise 0.
- wb_ACK  output  1  single-cycle acknowledge.
- busy  output  1  high in WAIT or ACK state (debug).

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named rst.
- Reset values:
  - state=IDLE; wb_ACK=0; wb_DAT_MISO=0; busy=0.
  - txn_count=0; wait_cfg=WAIT_STATES.
  - RAM contents are not reset.
- Address map:
  - ADR[13:12]==0: RAM, index ADR[DEPTH_LOG2-1:0]; higher bits within the region alias.
  - 14'h1000: ID, read-only; writes are ignored.
  - 14'h1001: txn_count, 16 bits zero-extended on read. Any write with any SEL bit set clears it to 0.
  - 14'h1002: wait_cfg[3:0]; write when SEL[0]=1; reads zero-extended.
  - All other addresses: ACK normally, read data 0, writes ignored.
- State machine: IDLE, WAIT, ACK.
  - IDLE: on a clk edge with CYC&STB=1, latch ADR/WE/SEL/MOSI and load wait_ctr=wait_cfg. Go to ACK if wait_cfg==0, else WAIT.
  - WAIT: decrement wait_ctr each cycle; when it reaches 0, go to ACK.
  - WAIT abort: if CYC=0 or STB=0 on any WAIT edge, return to IDLE. No write, no ACK, no count.
  - ACK: wb_ACK=1 for exactly one cycle, then IDLE. A new request is not sampled in the ACK cycle. Earliest back-to-back ACKs are 2 cycles apart.
- Latency: ACK rises wait_cfg+1 cycles after the edge that sampled the request.
- Write commit: on the edge entering ACK. Only lanes with SEL[n]=1 are updated; SEL=0 writes nothing but still ACKs.
- Read data: registered on the edge entering ACK from latched ADR; held only during the ACK cycle.
- txn_count:
  - Increments (16-bit, wraps 0xFFFF->0) on every edge entering ACK.
  - When that transaction is a write to 14'h1001, clear wins: result is 0.
  - A read of 14'h1001 returns the pre-increment value.
- wait_cfg change: a write to wait_cfg takes effect on the next request, never the current one.
- Reset mid-transaction: asserting rst in WAIT or ACK immediately forces IDLE and drops ACK. Any in-flight write not yet committed is lost.
- MOSI/ADR changes after the request has been sampled are ignored; the latched copies are used.

Test Plan:
- Reset, then read 14'h1000 with wait_cfg=1 -> ACK exactly 2 cycles after the sampling edge, MISO=32'hC0DE0401; MISO=0 outside the ACK cycle.
- Write 32'hAABBCCDD to RAM word 3 with SEL=4'b1111, then write 32'h11223344 with SEL=4'b0101 -> readback of word 3 = 32'hAA22CC44.
- Write 0 to 14'h1002 -> next read ACKs on the cycle after sampling. Write 15 -> next read ACKs 16 cycles after sampling.
- With wait_cfg=4, drop STB 2 cycles into a write to RAM word 0 -> no ACK, RAM unchanged, txn_count unchanged.
- Issue 5 transactions, then read 14'h1001 -> 5 returned (count now 6). Write 14'h1001 -> next read returns 0. Preload via 65536 transactions -> count wraps to 0.
- Assert rst during the WAIT of a RAM write -> ACK=0 immediately, state IDLE, target word keeps its old value, wait_cfg=WAIT_STATES.
